// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: architectural widths, FSM state encoding and
// the {pc, instr} record carried from instruction fetch to decode.
package fetch_unit_pkg;

   localparam int          XLEN             = 32;
   localparam int          INSTR_BYTES      = 4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic {
      ST_FETCH = 1'b0,
      ST_HALT  = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
      return pc + XLEN'(INSTR_BYTES);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO of {pc, instr} entries between fetch and decode.
// Flush empties it in one edge; the head holds its last shown value when empty.
module fetch_fifo
   import fetch_unit_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   push,
   input  fetch_entry_t           push_data,
   input  logic                   pop,
   output fetch_entry_t           head,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

   fetch_entry_t mem [DEPTH];
   fetch_entry_t hold_q;
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic          do_pop;

   assign do_pop = pop & (count_q != '0);
   assign head   = (count_q != '0) ? mem[rd_ptr_q] : hold_q;
   assign count  = count_q;

   always_ff @(posedge clk) begin
      if (rst) hold_q <= '0;
      else     hold_q <= head;

      if (rst || flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr_q] <= push_data;
            wr_ptr_q      <= wr_ptr_q + 1'b1;
         end
         if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + (AW + 1)'(push) - (AW + 1)'(do_pop);
      end
   end

   // The issue throttle upstream guarantees a push into a full FIFO always pairs with a pop.
   a_no_overflow: assert property (@(posedge clk) disable iff (rst || flush)
                                   !(push && !do_pop && count_q == FULL));

endmodule

// File: rtl/fetch_unit.sv
// Program counter, instruction_mem request sequencing, redirect/fault handling,
// and the {pc, instr} hand-off queue to decode.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int          IMEM_BYTES = 256,
   parameter int          DEPTH      = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic        fault,
   output logic [31:0] fault_pc
);

   localparam int          CW       = $clog2(DEPTH) + 1;
   localparam logic [31:0] PC_LIMIT = 32'(IMEM_BYTES - INSTR_BYTES);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, req_pc_q, fault_pc_q;
   logic         req_valid_q;
   logic [CW-1:0] count;
   logic [CW:0]   occ;
   fetch_entry_t  head;
   logic          pop, push, bad_pc, would_issue, issue, range_fault, redirect_misaligned;

   // Decode handshake: an entry transfers on a cycle where out_valid and out_ready are both high;
   // out_valid never depends on out_ready, and a redirect kills out_valid in the same cycle.
   assign out_valid = (count != '0) & ~redirect_valid;
   assign pop       = out_valid & out_ready;
   assign push      = req_valid_q & ~redirect_valid;

   // Occupancy includes the word still in flight from instruction_mem.
   assign occ         = (CW + 1)'(count) + (CW + 1)'(req_valid_q) - (CW + 1)'(pop);
   assign bad_pc      = (pc_q > PC_LIMIT) | (pc_q[1:0] != 2'b00);
   assign would_issue = (state_q == ST_FETCH) & ~redirect_valid & (occ < (CW + 1)'(DEPTH));
   assign issue       = would_issue & ~bad_pc;
   assign range_fault = would_issue & bad_pc;
   assign redirect_misaligned = redirect_valid & (redirect_pc[1:0] != 2'b00);

   always_comb begin
      state_d = state_q;
      if (redirect_valid)   state_d = redirect_misaligned ? ST_HALT : ST_FETCH;
      else if (range_fault) state_d = ST_HALT;
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_FETCH;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q        <= RESET_PC;
         req_pc_q    <= '0;
         req_valid_q <= 1'b0;
         fault_pc_q  <= '0;
      end else begin
         req_valid_q <= issue;
         if (redirect_valid) begin
            pc_q <= redirect_pc;
         end else if (issue) begin
            req_pc_q <= pc_q;
            pc_q     <= next_pc(pc_q);
         end
         if (redirect_misaligned) fault_pc_q <= redirect_pc;
         else if (range_fault)    fault_pc_q <= pc_q;
      end
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .push      (push),
      .push_data ('{pc: req_pc_q, instr: imem_instr}),
      .pop       (pop),
      .head      (head),
      .count     (count)
   );

   assign imem_addr = pc_q;
   assign out_pc    = head.pc;
   assign out_instr = head.instr;
   assign fault     = (state_q == ST_HALT);
   assign fault_pc  = fault_pc_q;

endmodule
